objective: RTL

//  Output-layer error source and the far end of the associate res/err handshakes.

---
 rtl/objective.sv | 99 +++++++++
 1 files changed

// File: rtl/objective.sv
// objective: output-layer error source; pairs a result with a target, returns a
// saturated delta on err_* and keeps saturating sample-count / squared-error statistics.
module objective #(
    parameter int SHIFT = 0,
    parameter int SQ    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        res_valid,
    input  logic [15:0] res_data,
    output logic        res_ready,
    input  logic        tgt_valid,
    input  logic [15:0] tgt_data,
    output logic        tgt_ready,
    output logic        err_valid,
    output logic [15:0] err_data,
    input  logic        err_ready,
    input  logic        clr,
    output logic [15:0] cnt_data,
    output logic [31:0] sse_data
);
    typedef enum logic [1:0] {CAP = 2'b00, CMP = 2'b01, ERR = 2'b10} state_t;
    state_t state;
    logic res_have, tgt_have, train_q;
    logic [15:0] res_q, tgt_q;
    logic signed [16:0] d17, shifted;
    logic signed [33:0] prod;
    logic [33:0] sq;
    logic [34:0] sse_sum;
    logic [15:0] sat;
    logic res_fire, tgt_fire;
    assign res_ready = reset && state == CAP && !res_have;
    assign tgt_ready = reset && state == CAP && !tgt_have;
    assign res_fire  = res_valid && res_ready;
    assign tgt_fire  = tgt_valid && tgt_ready;
    assign d17     = $signed({tgt_q[15], tgt_q}) - $signed({res_q[15], res_q});
    assign shifted = d17 >>> SHIFT;
    // bits 16 and 15 disagree only when the shifted delta is outside 16-bit range
    assign sat     = (shifted[16] != shifted[15]) ? {shifted[16], {15{~shifted[16]}}} : shifted[15:0];
    assign prod    = 34'(d17) * 34'(d17);
    assign sq      = prod >> SQ;
    assign sse_sum = {3'b0, sse_data} + {1'b0, sq};
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= CAP;
            res_have  <= 1'b0;
            tgt_have  <= 1'b0;
            train_q   <= 1'b0;
            res_q     <= '0;
            tgt_q     <= '0;
            err_valid <= 1'b0;
            err_data  <= '0;
            cnt_data  <= '0;
            sse_data  <= '0;
        end else begin
            case (state)
                CAP: begin
                    if (res_fire) begin
                        res_q    <= res_data;
                        res_have <= 1'b1;
                        train_q  <= train;
                    end
                    if (tgt_fire) begin
                        tgt_q    <= tgt_data;
                        tgt_have <= 1'b1;
                    end
                    if ((res_have || res_fire) && (tgt_have || tgt_fire)) state <= CMP;
                end
                CMP: begin
                    err_data  <= sat;
                    res_have  <= 1'b0;
                    tgt_have  <= 1'b0;
                    cnt_data  <= &cnt_data ? cnt_data : cnt_data + 16'd1;
                    sse_data  <= |sse_sum[34:32] ? 32'hFFFF_FFFF : sse_sum[31:0];
                    err_valid <= train_q;
                    state     <= train_q ? ERR : CAP;
                end
                ERR: begin
                    if (err_ready) begin
                        err_valid <= 1'b0;
                        state     <= CAP;
                    end
                end
                default: begin
`ifndef SYNTHESIS
                    $display("objective: illegal state code %b", state);
`endif
                    state <= CAP;
                end
            endcase
            // placed after the update so a coincident clear wins
            if (clr) begin
                cnt_data <= '0;
                sse_data <= '0;
            end
        end
    end
endmodule
